// File: rtl/rca_pipe_collect_if.sv
// Handshake bundle between the adder/upstream issuer, the collect stage and the
// result consumer.
interface rca_pipe_collect_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;

  modport master (
    output in_valid, sum_in, cout_in, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, sum_in, cout_in, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rca_pipe_collect.sv
// Result-collection stage for a valid-less pipelined adder: tags issue cycles,
// captures {cout, sum} LAT edges later into a credit-protected show-ahead FIFO.
module rca_pipe_collect #(
  parameter int unsigned LAT   = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rca_pipe_collect_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = WIDTH + 1;

  logic [LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]  mem_q [DEPTH];

  logic fire_c, wr_c, pop_c, in_ready_c, out_valid_c;

  // Credits come from registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready_c  = ((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
  assign out_valid_c = (count_q != '0);
  assign fire_c      = bus.in_valid && in_ready_c;
  assign wr_c        = tag_q[LAT-1];
  assign pop_c       = out_valid_c && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    tag_d      = (tag_q << 1) | LAT'(fire_c);
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    unique case ({fire_c, wr_c})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_c)  wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is left unreset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= {bus.cout_in, bus.sum_in};
  end

endmodule

// File: tb/tb_rca_pipe_collect.sv
// Directed bench for rca_pipe_collect with a behavioural LAT-stage adder in front.
module tb_rca_pipe_collect;

  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rca_pipe_collect_if #(.WIDTH(WIDTH)) bus ();

  rca_pipe_collect #(.LAT(LAT), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WIDTH-1:0] op_a, op_b;
  logic             op_c;
  logic [WIDTH:0]   pipe [LAT];

  // Free-running adder: no valid, no reset.
  always @(posedge clk) begin
    pipe[0] <= (WIDTH+1)'(op_a) + (WIDTH+1)'(op_b) + (WIDTH+1)'(op_c);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.sum_in  = pipe[LAT-1][WIDTH-1:0];
  assign bus.cout_in = pipe[LAT-1][WIDTH];

  int n_total = 0;
  int n_bad   = 0;
  int n_fire  = 0;
  int n_pop   = 0;
  int cyc     = 0;
  int first_pop_cyc, last_pop_cyc;
  logic [WIDTH:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs already set; crosses one posedge.
  task automatic tick();
    #1;
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(9'(op_a) + 9'(op_b) + 9'(op_c));
      n_fire++;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(bus.out_data), 32'h1ff);
      else chk("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      if (n_pop == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      n_pop++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.in_valid = v;
    op_a = a;
    op_b = b;
    op_c = c;
  endtask

  always @(posedge clk) begin
    if (rst_n && dut.wr_c && dut.count_q == 5'(DEPTH)) chk("write_into_full", 32'd1, 32'd0);
  end

  initial begin
    int guard;
    int vcount;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single add 0x5A + 0x3C + 1
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h5A, 8'h3C, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 50) begin tick(); guard++; end
    chk("single_latency", 32'(guard), 32'(LAT));
    chk("single_data", 32'(bus.out_data), 32'h097);
    tick();
    chk("single_popped", 32'(bus.out_valid), 32'd0);

    // Carry out 0xFF + 0x01
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    guard = 0;
    while (!bus.out_valid && guard < 50) begin tick(); guard++; end
    chk("carry_latency", 32'(guard), 32'(LAT));
    chk("carry_data", 32'(bus.out_data), 32'h100);
    tick();

    // Streaming 40 operands
    n_pop = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'(i), 8'(2 * i), i[0]);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin tick(); guard++; end
    chk("stream_count", 32'(n_pop), 32'd40);
    chk("stream_back_to_back", 32'(last_pop_cyc - first_pop_cyc), 32'd39);

    // Backpressure
    bus.out_ready = 1'b0;
    n_fire = 0;
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, 8'(k + 100), 8'(3 * k), k[1]);
      tick();
      if (k == 15) chk("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
    end
    chk("bp_fires", 32'(n_fire), 32'(DEPTH));
    chk("bp_count_full", 32'(dut.count_q), 32'(DEPTH));
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_in_ready_recover", 32'(bus.in_ready), 32'd1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin tick(); guard++; end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Simultaneous write and pop at count 3
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(k + 8'h40), 8'(k + 8'h11), 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (7) tick();
    chk("sim_count_before", 32'(dut.count_q), 32'd3);
    bus.out_ready = 1'b1;
    tick();
    chk("sim_count_after", 32'(dut.count_q), 32'd3);
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    chk("sim_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation: 2 buffered, 3 in flight
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(k + 8'h80), 8'h05, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (5) tick();
    chk("mid_buffered", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      #1;
      if (bus.out_valid) vcount++;
      tick();
    end
    chk("mid_no_results", 32'(vcount), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
